// File: rtl/power_detector.sv
// Windowed |I|+|Q| power per channel, max-combined, with hysteresis trigger FSM; power 2 cycles, trigger 3 cycles after an accepted sample.
// No backpressure: advances only on signal_valid_in, 1 sample/cycle; POWER_DET_TIMEOUT_EN adds packet-length timeout and REARM state.
module power_detector #(
   parameter int DATA_WIDTH  = 16,
   parameter int NUM_CH      = 2,
   parameter int AVG_LOG2    = 4,
   parameter int HOLD_LEN    = 80,
   parameter int SKIP_SAMPLE = 0,
   parameter int MAX_PKT_LEN = 4096
) (
   input  logic                           clk_in,
   input  logic                           rst_in,
   input  logic [DATA_WIDTH:0]            thresh_hi_in,
   input  logic [DATA_WIDTH:0]            thresh_lo_in,
   input  logic [NUM_CH*2*DATA_WIDTH-1:0] signal_data_in,
   input  logic                           signal_valid_in,
   output logic [DATA_WIDTH:0]            power_out,
   output logic                           power_valid_out,
   output logic                           trigger_out,
   output logic [NUM_CH-1:0]              active_ch_out,
   output logic                           timeout_out
);
   localparam int MAG_W = DATA_WIDTH + 1;
   localparam int SUM_W = MAG_W + AVG_LOG2;
   localparam int DEPTH = 2 ** AVG_LOG2;
   localparam logic [15:0] WARM_LAST = 16'(DEPTH + SKIP_SAMPLE - 1);
   localparam logic [15:0] HOLD_LAST = 16'(HOLD_LEN - 1);

`ifdef POWER_DET_TIMEOUT_EN
   localparam logic [15:0] PKT_LAST = 16'(MAX_PKT_LEN - 1);
   typedef enum logic [1:0] {WARMUP, IDLE, PACKET, REARM} state_t;
`else
   typedef enum logic [1:0] {WARMUP, IDLE, PACKET} state_t;
`endif

   // Sign-extend before negating so that |-2^(W-1)| = 2^(W-1) fits.
   function automatic logic [MAG_W-1:0] abs_ext(input logic [DATA_WIDTH-1:0] x);
      logic [MAG_W-1:0] e;
      e = {x[DATA_WIDTH-1], x};
      return x[DATA_WIDTH-1] ? (~e + MAG_W'(1)) : e;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic [MAG_W-1:0] mag    [NUM_CH];
   logic [MAG_W-1:0] dline  [NUM_CH][DEPTH];
   logic [SUM_W-1:0] sum    [NUM_CH];
   logic [MAG_W-1:0] ch_avg [NUM_CH];
   logic [MAG_W-1:0] max_avg;
   logic             sum_vld;
   logic [NUM_CH-1:0] ch_hi;

   state_t      state, state_nxt;
   logic        trig_nxt;
   logic [NUM_CH-1:0] act_nxt;
   logic [15:0] hold_cnt, hold_nxt;
   logic [15:0] warm_cnt, warm_nxt;
`ifdef POWER_DET_TIMEOUT_EN
   logic [15:0] pkt_cnt, pkt_nxt;
   logic        tmo_nxt;
`endif

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         mag[c] = abs_ext(signal_data_in[c*2*DATA_WIDTH + 2*DATA_WIDTH-1 -: DATA_WIDTH])
                + abs_ext(signal_data_in[c*2*DATA_WIDTH + DATA_WIDTH-1 -: DATA_WIDTH]);
      end
   end

   always_comb begin
      max_avg = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (sum[c][SUM_W-1:AVG_LOG2] > max_avg) max_avg = sum[c][SUM_W-1:AVG_LOG2];
      end
   end

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) ch_hi[c] = (ch_avg[c] >= thresh_hi_in);
   end

   // Stage A: delay line and running sum per channel.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         sum_vld <= 1'b0;
         for (int c = 0; c < NUM_CH; c++) begin
            sum[c] <= '0;
            for (int d = 0; d < DEPTH; d++) dline[c][d] <= '0;
         end
      end else begin
         sum_vld <= signal_valid_in;
         if (signal_valid_in) begin
            for (int c = 0; c < NUM_CH; c++) begin
               sum[c]      <= sum[c] + SUM_W'(mag[c]) - SUM_W'(dline[c][DEPTH-1]);
               dline[c][0] <= mag[c];
               for (int d = 1; d < DEPTH; d++) dline[c][d] <= dline[c][d-1];
            end
         end
      end
   end

   // Stage B: averages and channel maximum.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         power_out       <= '0;
         power_valid_out <= 1'b0;
         for (int c = 0; c < NUM_CH; c++) ch_avg[c] <= '0;
      end else begin
         power_valid_out <= sum_vld;
         if (sum_vld) begin
            power_out <= max_avg;
            for (int c = 0; c < NUM_CH; c++) ch_avg[c] <= sum[c][SUM_W-1:AVG_LOG2];
         end
      end
   end

   // Stage C: trigger FSM, evaluated once per average.
   always_comb begin
      state_nxt = state;
      trig_nxt  = trigger_out;
      act_nxt   = active_ch_out;
      hold_nxt  = hold_cnt;
      warm_nxt  = warm_cnt;
`ifdef POWER_DET_TIMEOUT_EN
      pkt_nxt   = pkt_cnt;
      tmo_nxt   = 1'b0;
`endif
      if (power_valid_out) begin
         case (state)
            WARMUP: begin
               if (warm_cnt >= WARM_LAST) state_nxt = IDLE;
               else                       warm_nxt  = sat_inc(warm_cnt);
            end
            IDLE: begin
               if (power_out >= thresh_hi_in) begin
                  trig_nxt  = 1'b1;
                  act_nxt   = ch_hi;
                  hold_nxt  = '0;
                  state_nxt = PACKET;
`ifdef POWER_DET_TIMEOUT_EN
                  pkt_nxt   = '0;
`endif
               end
            end
            PACKET: begin
               if (power_out < thresh_lo_in) begin
                  if (hold_cnt >= HOLD_LAST) begin
                     trig_nxt  = 1'b0;
                     state_nxt = IDLE;
                  end else begin
                     hold_nxt = sat_inc(hold_cnt);
                  end
               end else begin
                  hold_nxt = '0;
               end
`ifdef POWER_DET_TIMEOUT_EN
               // Timeout overrides the hold-off outcome of the same evaluation.
               pkt_nxt = sat_inc(pkt_cnt);
               if (pkt_cnt >= PKT_LAST) begin
                  trig_nxt  = 1'b0;
                  tmo_nxt   = 1'b1;
                  hold_nxt  = '0;
                  state_nxt = REARM;
               end
`endif
            end
`ifdef POWER_DET_TIMEOUT_EN
            REARM: begin
               if (power_out < thresh_lo_in) state_nxt = IDLE;
            end
`endif
            default: state_nxt = WARMUP;
         endcase
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state         <= WARMUP;
         trigger_out   <= 1'b0;
         active_ch_out <= '0;
         hold_cnt      <= '0;
         warm_cnt      <= '0;
      end else begin
         state         <= state_nxt;
         trigger_out   <= trig_nxt;
         active_ch_out <= act_nxt;
         hold_cnt      <= hold_nxt;
         warm_cnt      <= warm_nxt;
      end
   end

`ifdef POWER_DET_TIMEOUT_EN
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         pkt_cnt     <= '0;
         timeout_out <= 1'b0;
      end else begin
         pkt_cnt     <= pkt_nxt;
         timeout_out <= tmo_nxt;
      end
   end
`else
   assign timeout_out = 1'b0;
`endif

endmodule

// File: tb/tb_power_detector.sv
// Directed table-driven bench for power_detector (default build, 2 channels, 16-sample window, HOLD_LEN 80).
module tb_power_detector;
   localparam int W = 16;

   logic           clk_in = 1'b0;
   logic           rst_in;
   logic [W:0]     thresh_hi_in;
   logic [W:0]     thresh_lo_in;
   logic [4*W-1:0] signal_data_in;
   logic           signal_valid_in;
   logic [W:0]     power_out;
   logic           power_valid_out;
   logic           trigger_out;
   logic [1:0]     active_ch_out;
   logic           timeout_out;

   int checks = 0;
   int errors = 0;

   always #5 clk_in = ~clk_in;

   power_detector #(
      .DATA_WIDTH(W), .NUM_CH(2), .AVG_LOG2(4), .HOLD_LEN(80), .SKIP_SAMPLE(0), .MAX_PKT_LEN(4096)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .thresh_hi_in(thresh_hi_in), .thresh_lo_in(thresh_lo_in),
      .signal_data_in(signal_data_in), .signal_valid_in(signal_valid_in),
      .power_out(power_out), .power_valid_out(power_valid_out),
      .trigger_out(trigger_out), .active_ch_out(active_ch_out),
      .timeout_out(timeout_out)
   );

   typedef struct {
      logic [W-1:0] i0, q0, i1, q1;
      int           pwr;
      logic         trig;
   } vec_t;

   function automatic vec_t mk(input int i0, input int q0, input int i1, input int q1,
                               input int pwr, input logic trig);
      vec_t v;
      v.i0 = W'(i0); v.q0 = W'(q0); v.i1 = W'(i1); v.q1 = W'(q1);
      v.pwr = pwr; v.trig = trig;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] got %0d expected %0d", nm, idx, act, exp);
      end
   endtask

   // One accepted sample followed by idle cycles; checks power at +2 and trigger at +3.
   task automatic apply(input vec_t v, input logic [W:0] lo, input string nm, input int idx);
      @(negedge clk_in);
      signal_data_in  = {v.i1, v.q1, v.i0, v.q0};
      signal_valid_in = 1'b1;
      thresh_lo_in    = lo;
      @(negedge clk_in);
      signal_valid_in = 1'b0;
      chk({nm, "_gap"}, idx, 32'(power_valid_out), 32'd0);
      @(negedge clk_in);
      chk({nm, "_pvld"}, idx, 32'(power_valid_out), 32'd1);
      chk({nm, "_pwr"}, idx, 32'(power_out), v.pwr);
      @(negedge clk_in);
      chk({nm, "_trig"}, idx, 32'(trigger_out), 32'(v.trig));
      thresh_lo_in = 17'd300;
   endtask

   vec_t t1 [32];
   vec_t t2 [17];
   int   r700 [16];
   int   r500 [16];

   initial begin
      r700 = '{43, 87, 131, 175, 218, 262, 306, 350, 393, 437, 481, 525, 568, 612, 656, 700};
      r500 = '{31, 62, 93, 125, 156, 187, 218, 250, 281, 312, 343, 375, 406, 437, 468, 500};
      for (int i = 0; i < 16; i++) t1[i] = mk(0, 0, 0, 0, 0, 1'b0);
      for (int k = 0; k < 16; k++) t1[16+k] = mk(400, -300, 0, 0, r700[k], k >= 11);
      for (int k = 0; k < 16; k++) t2[k] = mk(0, 500, 0, 0, r500[k], 1'b0);
      t2[16] = mk(0, 500, 0, 0, 500, 1'b1);

      rst_in = 1'b1;
      signal_valid_in = 1'b0;
      signal_data_in  = '0;
      thresh_hi_in    = 17'd500;
      thresh_lo_in    = 17'd300;
      repeat (3) @(negedge clk_in);
      chk("rst_pwr", 0, 32'(power_out), 32'd0);
      chk("rst_pvld", 0, 32'(power_valid_out), 32'd0);
      chk("rst_trig", 0, 32'(trigger_out), 32'd0);
      chk("rst_act", 0, 32'(active_ch_out), 32'd0);
      chk("rst_tmo", 0, 32'(timeout_out), 32'd0);
      rst_in = 1'b0;

      // Zero warmup then 700 ramp; trigger when average first reaches >= 500.
      for (int i = 0; i < 32; i++) apply(t1[i], 17'd300, "ramp", i);
      chk("ramp_act", 0, 32'(active_ch_out), 32'd1);

      // Drain to zero: first low at zero #10; lo forced to 0 at #51 restarts count; 80 lows end at #131.
      for (int j = 1; j <= 131; j++) begin
         apply(mk(0, 0, 0, 0, (j <= 16) ? (700 * (16 - j)) / 16 : 0, j < 131),
               (j == 51) ? 17'd0 : 17'd300, "hold", j);
      end

      // Full-scale negative on ch1: 65536 magnitude, no wrap, ch1 flagged.
      for (int k = 1; k <= 16; k++) apply(mk(0, 0, -32768, -32768, 4096 * k, 1'b1), 17'd300, "full", k);
      chk("full_act", 0, 32'(active_ch_out), 32'd2);

      // Back-to-back zeros: drain values must match the gapped ramp steps.
      for (int k = 1; k <= 18; k++) begin
         @(negedge clk_in);
         if (k >= 3) begin
            chk("b2b_pvld", k, 32'(power_valid_out), 32'd1);
            chk("b2b_pwr", k, 32'(power_out), 32'(65536 - 4096 * (k - 2)));
         end
         signal_data_in  = '0;
         signal_valid_in = (k <= 16);
      end
      chk("pre_rst_trig", 0, 32'(trigger_out), 32'd1);

      // Asynchronous reset between clock edges.
      @(negedge clk_in);
      #2 rst_in = 1'b1;
      #1;
      chk("arst_trig", 0, 32'(trigger_out), 32'd0);
      chk("arst_pwr", 0, 32'(power_out), 32'd0);
      chk("arst_act", 0, 32'(active_ch_out), 32'd0);
      @(negedge clk_in);
      rst_in = 1'b0;

      // Warmup re-runs for 16 samples even though average reaches hi at sample 16.
      for (int i = 0; i < 17; i++) apply(t2[i], 17'd300, "rewarm", i);
      chk("rewarm_act", 0, 32'(active_ch_out), 32'd1);

`ifndef POWER_DET_TIMEOUT_EN
      chk("tmo_tied", 0, 32'(timeout_out), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
